// File: rtl/aes_pkg.sv
// Shared AES-128 decryption types, constants and GF(2^8) helpers.
package aes_pkg;

   typedef enum logic [2:0] {
      IDLE, KEYEXP, ARK0, INV_SHIFT, INV_SUB, ARK, INV_MIX, DONE
   } aes_state_e;

   localparam logic [7:0] RCON [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (0 maps to 0), keeps the S-boxes table-free.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, a252;
      a2   = gmul(a, a);
      a3   = gmul(a2, a);
      a6   = gmul(a3, a3);
      a12  = gmul(a6, a6);
      a15  = gmul(a12, a3);
      a30  = gmul(a15, a15);
      a60  = gmul(a30, a30);
      a120 = gmul(a60, a60);
      a240 = gmul(a120, a120);
      a252 = gmul(a240, a12);
      return gmul(a252, a2);
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] s);
      logic [7:0] b;
      b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
      return gf_inv(b);
   endfunction

   // Byte 4c+r (row r, column c) sits at [127-8*(4c+r) -: 8].
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
      return o;
   endfunction

   function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
              gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
              gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
              gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) o[127-32*c -: 32] = inv_mix_column(s[127-32*c -: 32]);
      return o;
   endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion step: next round key from the previous one.
module aes_key_step
   import aes_pkg::*;
(
   input  logic [127:0] rk_prev,
   input  logic [7:0]   rcon,
   output logic [127:0] rk_next
);

   logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;

   // RotWord + SubWord + Rcon on the last word, then the xor chain across words.
   always_comb begin
      w0 = rk_prev[127:96];
      w1 = rk_prev[95:64];
      w2 = rk_prev[63:32];
      w3 = rk_prev[31:0];
      t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon, 24'h000000};
      n0 = w0 ^ t;
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
      rk_next = {n0, n1, n2, n3};
   end

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 decryption: key expansion, then one inverse-round operation per cycle.
// Handshake: AES_START is a level request sampled only in IDLE; AES_DONE stays high in DONE
// until AES_START is low, so a START dropped mid-run yields a one-cycle DONE pulse.
module aes_decrypt_core
   import aes_pkg::*;
#(
   parameter int NUM_ROUNDS = 10
)(
   input  logic         CLK,
   input  logic         RESET,
   input  logic         AES_START,
   input  logic [127:0] AES_KEY,
   input  logic [127:0] AES_MSG_ENC,
   output logic         AES_DONE,
   output logic [127:0] AES_MSG_DEC
);

   aes_state_e   fsm_q, fsm_d;
   logic [3:0]   round_q, round_d;
   logic [3:0]   kcnt_q, kcnt_d;
   logic         final_q, final_d;
   logic         done_q, done_d;
   logic [127:0] st_q, st_d;
   logic [127:0] dec_q, dec_d;
   logic [127:0] rk_q [0:NUM_ROUNDS];
   logic [127:0] rk_d [0:NUM_ROUNDS];
   logic [127:0] ks_prev, ks_next, rk_sel;
   logic [7:0]   ks_rcon;

   aes_key_step u_key_step (
      .rk_prev (ks_prev),
      .rcon    (ks_rcon),
      .rk_next (ks_next)
   );

   // Key-step source: previous round key and rcon selected by the key-step counter.
   always_comb begin
      ks_prev = rk_q[0];
      ks_rcon = RCON[0];
      for (int i = 1; i <= NUM_ROUNDS; i++) begin
         if (kcnt_q == 4'(i)) begin
            ks_prev = rk_q[i-1];
            ks_rcon = RCON[i-1];
         end
      end
   end

   // Round key for ARK: rk[r] in inner rounds, rk[0] in the final round.
   always_comb begin
      rk_sel = rk_q[0];
      if (!final_q) begin
         for (int i = 1; i <= NUM_ROUNDS; i++) begin
            if (round_q == 4'(i)) rk_sel = rk_q[i];
         end
      end
   end

   // Next-state and datapath update for the decryption sequencer.
   always_comb begin
      fsm_d   = fsm_q;
      round_d = round_q;
      kcnt_d  = kcnt_q;
      final_d = final_q;
      done_d  = done_q;
      st_d    = st_q;
      dec_d   = dec_q;
      for (int i = 0; i <= NUM_ROUNDS; i++) rk_d[i] = rk_q[i];
      case (fsm_q)
         IDLE: begin
            if (AES_START) begin
               rk_d[0] = AES_KEY;
               st_d    = AES_MSG_ENC;
               kcnt_d  = 4'd1;
               round_d = 4'd0;
               final_d = 1'b0;
               fsm_d   = KEYEXP;
            end
         end
         KEYEXP: begin
            for (int i = 1; i <= NUM_ROUNDS; i++) begin
               if (kcnt_q == 4'(i)) rk_d[i] = ks_next;
            end
            if (kcnt_q == 4'(NUM_ROUNDS)) fsm_d = ARK0;
            else                          kcnt_d = kcnt_q + 4'd1;
         end
         ARK0: begin
            st_d    = st_q ^ rk_q[NUM_ROUNDS];
            round_d = 4'(NUM_ROUNDS - 1);
            fsm_d   = INV_SHIFT;
         end
         INV_SHIFT: begin
            st_d  = inv_shift_rows(st_q);
            fsm_d = INV_SUB;
         end
         INV_SUB: begin
            st_d  = inv_sub_bytes(st_q);
            fsm_d = ARK;
         end
         ARK: begin
            st_d = st_q ^ rk_sel;
            if (final_q) begin
               dec_d  = st_q ^ rk_sel;
               done_d = 1'b1;
               fsm_d  = DONE;
            end else begin
               fsm_d = INV_MIX;
            end
         end
         INV_MIX: begin
            st_d = inv_mix_columns(st_q);
            if (round_q == 4'd1) final_d = 1'b1;
            else                 round_d = round_q - 4'd1;
            fsm_d = INV_SHIFT;
         end
         DONE: begin
            if (!AES_START) begin
               done_d = 1'b0;
               fsm_d  = IDLE;
            end
         end
         default: fsm_d = IDLE;
      endcase
   end

   // State, key schedule and output registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         fsm_q   <= IDLE;
         round_q <= 4'd0;
         kcnt_q  <= 4'd0;
         final_q <= 1'b0;
         done_q  <= 1'b0;
         st_q    <= '0;
         dec_q   <= '0;
         for (int i = 0; i <= NUM_ROUNDS; i++) rk_q[i] <= '0;
      end else begin
         fsm_q   <= fsm_d;
         round_q <= round_d;
         kcnt_q  <= kcnt_d;
         final_q <= final_d;
         done_q  <= done_d;
         st_q    <= st_d;
         dec_q   <= dec_d;
         for (int i = 0; i <= NUM_ROUNDS; i++) rk_q[i] <= rk_d[i];
      end
   end

   assign AES_DONE    = done_q;
   assign AES_MSG_DEC = dec_q;

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Directed bench for aes_decrypt_core using FIPS-197 vectors.
module tb_aes_decrypt_core;
   import aes_pkg::*;

   localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] ENC1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] DEC1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] RK1  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] ENC2 = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] DEC2 = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] RK2  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   logic         clk;
   logic         reset;
   logic         aes_start;
   logic [127:0] aes_key;
   logic [127:0] aes_msg_enc;
   logic         aes_done;
   logic [127:0] aes_msg_dec;

   int checks = 0;
   int errors = 0;

   aes_decrypt_core dut (
      .CLK         (clk),
      .RESET       (reset),
      .AES_START   (aes_start),
      .AES_KEY     (aes_key),
      .AES_MSG_ENC (aes_msg_enc),
      .AES_DONE    (aes_done),
      .AES_MSG_DEC (aes_msg_dec)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at the negedge where START was raised; checks DONE low after edge 50, high after edge 51.
   task automatic wait_result(input string tag, input logic [127:0] prev, input logic [127:0] res);
      repeat (50) @(negedge clk);
      chk({tag, "_done_low_e50"}, 128'(aes_done), 128'd0);
      chk({tag, "_dec_held_e50"}, aes_msg_dec, prev);
      @(negedge clk);
      chk({tag, "_done_high_e51"}, 128'(aes_done), 128'd1);
      chk({tag, "_dec_e51"}, aes_msg_dec, res);
   endtask

   initial begin
      reset       = 1'b1;
      aes_start   = 1'b0;
      aes_key     = '0;
      aes_msg_enc = '0;
      repeat (2) @(negedge clk);
      chk("reset_done", 128'(aes_done), 128'd0);
      chk("reset_dec", aes_msg_dec, 128'd0);
      chk("reset_state", 128'(dut.fsm_q), 128'(IDLE));
      reset = 1'b0;

      // Vector 1, START held through DONE
      @(negedge clk);
      aes_key = KEY1; aes_msg_enc = ENC1; aes_start = 1'b1;
      wait_result("v1", 128'd0, DEC1);
      chk("v1_rk10", dut.rk_q[10], RK1);

      // DONE held while START stays high
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("hold_done", 128'(aes_done), 128'd1);
         chk("hold_dec", aes_msg_dec, DEC1);
      end
      aes_start = 1'b0;
      @(negedge clk);
      chk("drop_done", 128'(aes_done), 128'd0);
      chk("drop_state", 128'(dut.fsm_q), 128'(IDLE));
      chk("drop_dec", aes_msg_dec, DEC1);

      // Vector 2 straight after: DEC keeps result 1 until DONE of run 2
      aes_key = KEY2; aes_msg_enc = ENC2; aes_start = 1'b1;
      wait_result("v2", DEC1, DEC2);
      chk("v2_rk10", dut.rk_q[10], RK2);
      aes_start = 1'b0;
      @(negedge clk);
      chk("v2_drop_done", 128'(aes_done), 128'd0);

      // One-cycle START pulse, inputs zeroed right after capture
      aes_key = KEY1; aes_msg_enc = ENC1; aes_start = 1'b1;
      @(negedge clk);
      aes_start = 1'b0; aes_key = '0; aes_msg_enc = '0;
      repeat (49) @(negedge clk);
      chk("pulse_done_low_e50", 128'(aes_done), 128'd0);
      chk("pulse_dec_held_e50", aes_msg_dec, DEC2);
      @(negedge clk);
      chk("pulse_done_high_e51", 128'(aes_done), 128'd1);
      chk("pulse_dec_e51", aes_msg_dec, DEC1);
      @(negedge clk);
      chk("pulse_done_fall", 128'(aes_done), 128'd0);
      chk("pulse_state_idle", 128'(dut.fsm_q), 128'(IDLE));
      chk("pulse_dec_kept", aes_msg_dec, DEC1);

      // Reset at edge 25 of a run, then a fresh run
      aes_key = KEY2; aes_msg_enc = ENC2; aes_start = 1'b1;
      repeat (24) @(negedge clk);
      reset = 1'b1; aes_start = 1'b0;
      @(negedge clk);
      chk("midrst_done", 128'(aes_done), 128'd0);
      chk("midrst_dec", aes_msg_dec, 128'd0);
      chk("midrst_state", 128'(dut.fsm_q), 128'(IDLE));
      chk("midrst_rk10", dut.rk_q[10], 128'd0);
      reset = 1'b0; aes_start = 1'b1;
      wait_result("post_rst", 128'd0, DEC2);
      chk("post_rst_rk10", dut.rk_q[10], RK2);
      aes_start = 1'b0;
      @(negedge clk);
      chk("post_rst_drop_done", 128'(aes_done), 128'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
